conv_scheduler: RTL and testbench



---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_mac.sv | 38 +++
 rtl/conv_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_conv_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and geometry helper for the sequential convolution scheduler.
package conv_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        EMIT
    } state_t;

    function automatic int conv_out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single signed multiply-accumulate with clear and enable; 32-bit wrapping sum.
// acc_next exposes the value the accumulator takes on the coming edge.
module conv_mac
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] acc_next
);

    word_t prod;
    word_t acc_q;
    word_t acc_d;

    always_comb begin
        // Only the low word of the signed product is kept.
        prod  = word_t'($signed(a) * $signed(b));
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? prod : acc_q + prod;
        end
    end

    assign acc_next = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Resource-shared convolution: buffer filter + feature map, one MAC per cycle.
// Define CONV_SCHED_RELU_EN to clamp negative results to zero on output.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int input_size  = 7,
    parameter int filter_size = 3,
    parameter int stride      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    localparam int N   = input_size;
    localparam int K   = filter_size;
    localparam int S   = stride;
    localparam int KK  = K * K;
    localparam int NN  = N * N;
    localparam int LDN = KK + NN;
    localparam int O   = conv_out_dim(N, K, S);
    localparam int FAW = (KK > 1) ? $clog2(KK) : 1;
    localparam int IAW = (NN > 1) ? $clog2(NN) : 1;
    localparam int LW  = $clog2(LDN);
    localparam int KW  = (K > 1) ? $clog2(K) : 1;
    localparam int OW  = (O > 1) ? $clog2(O) : 1;

    state_t          state_q, state_d;
    logic [LW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [KW-1:0]   kr_q, kr_d, kc_q, kc_d;
    logic [OW-1:0]   r_q, r_d, c_q, c_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;
    word_t           out_data_q, out_data_d;

    word_t           filt_q [KK];
    word_t           img_q  [NN];

    logic            filt_we, img_we;
    logic [FAW-1:0]  f_addr, ld_faddr;
    logic [IAW-1:0]  i_addr, ld_iaddr;
    logic            mac_en, mac_clr, k_last, pos_last;
    word_t           mac_next, res;

    conv_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (filt_q[f_addr]),
        .b        (img_q[i_addr]),
        .acc_next (mac_next)
    );

    always_comb begin
        f_addr   = FAW'(int'(kr_q) * K + int'(kc_q));
        i_addr   = IAW'((int'(r_q) * S + int'(kr_q)) * N + int'(c_q) * S + int'(kc_q));
        ld_faddr = FAW'(ld_cnt_q);
        ld_iaddr = IAW'(int'(ld_cnt_q) - KK);
        k_last   = (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
        pos_last = (r_q == OW'(O - 1)) && (c_q == OW'(O - 1));
`ifdef CONV_SCHED_RELU_EN
        res = mac_next[31] ? '0 : mac_next;
`else
        res = mac_next;
`endif

        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        r_d         = r_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        filt_we     = 1'b0;
        img_we      = 1'b0;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    ld_cnt_d = '0;
                    r_d      = '0;
                    c_d      = '0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    filt_we = int'(ld_cnt_q) < KK;
                    img_we  = int'(ld_cnt_q) >= KK;
                    if (ld_cnt_q == LW'(LDN - 1)) begin
                        state_d = MAC;
                        kr_d    = '0;
                        kc_d    = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LW'(1);
                    end
                end
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (kr_q == '0) && (kc_q == '0);
                if (kc_q == KW'(K - 1)) begin
                    kc_d = '0;
                    kr_d = kr_q + KW'(1);
                end else begin
                    kc_d = kc_q + KW'(1);
                end
                if (k_last) begin
                    state_d     = EMIT;
                    kr_d        = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = pos_last;
                    out_data_d  = res;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (pos_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = MAC;
                        if (c_q == OW'(O - 1)) begin
                            c_d = '0;
                            r_d = r_q + OW'(1);
                        end else begin
                            c_d = c_q + OW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            r_q         <= r_d;
            c_q         <= c_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            if (filt_we) filt_q[ld_faddr] <= in_data;
            if (img_we) img_q[ld_iaddr] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler (7/3/2 main instance, 3/3/1 degenerate).
module tb_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_last, busy;
    logic [31:0] out_data;

    logic        start3, in_valid3, out_ready3;
    logic [31:0] in_data3;
    logic        in_ready3, out_valid3, out_last3, busy3;
    logic [31:0] out_data3;

    always #5 clk = ~clk;

    conv_scheduler #(.input_size(7), .filter_size(3), .stride(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy)
    );

    conv_scheduler #(.input_size(3), .filter_size(3), .stride(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_last(out_last3),
        .busy(busy3)
    );

    int n_vec = 0;
    int n_err = 0;

    int f_arr [9];
    int i_arr [49];
    int basic_exp [9] = '{72, 90, 108, 198, 216, 234, 324, 342, 360};

    int res_q [$];
    bit last_q [$];
    int stall_q [$];
    int in_cyc, busy_cyc, last_ld_cyc, first_ov, last_out_cyc, end_cyc;
    bit timed_out, aborted;

    function automatic int relu(input int v);
`ifdef CONV_SCHED_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Direct window sum for output (r,c) of the 7/3/2 geometry.
    function automatic int model(input int r, input int c);
        int acc = 0;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
                acc += f_arr[kr*3+kc] * i_arr[(r*2+kr)*7 + c*2 + kc];
        return relu(acc);
    endfunction

    task automatic fill_basic(input int fval);
        for (int j = 0; j < 9; j++) f_arr[j] = fval;
        for (int j = 0; j < 49; j++) i_arr[j] = j;
    endtask

    // mode 0: steady streams, 1: random gaps/backpressure/start noise,
    // 2: 5-cycle stall on the second output. abort_at>0: reset mid-MAC.
    task automatic run_job(input int mode, input int abort_at);
        int idx = 0;
        int cyc = 0;
        int hold = 0;
        int wait_ab = 0;
        res_q.delete(); last_q.delete(); stall_q.delete();
        in_cyc = 0; busy_cyc = 0; last_ld_cyc = -1; first_ov = -1;
        last_out_cyc = -1; timed_out = 0; aborted = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy && cyc < 3000) begin
            busy_cyc++;
            if (in_ready) in_cyc++;
            if (mode == 1) begin
                in_valid = $urandom_range(0, 1) == 1;
                start    = $urandom_range(0, 1) == 1;
            end else begin
                in_valid = idx < 58;
            end
            if (idx < 9) in_data = f_arr[idx];
            else if (idx < 58) in_data = i_arr[idx-9];
            else in_data = $urandom;
            out_ready = 1'b1;
            if (mode == 1) out_ready = $urandom_range(0, 1) == 1;
            if (mode == 2 && out_valid && res_q.size() == 1 && hold < 5) begin
                out_ready = 1'b0;
                hold++;
                stall_q.push_back(out_data);
            end
            if (in_valid && in_ready && idx < 58) begin
                idx++;
                last_ld_cyc = cyc;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                res_q.push_back(out_data);
                last_q.push_back(out_last);
                last_out_cyc = cyc;
            end
            if (abort_at > 0 && res_q.size() == abort_at) begin
                wait_ab++;
                if (wait_ab == 4) begin
                    rst = 1'b1;
                    aborted = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (aborted) begin
                rst = 1'b0;
                break;
            end
        end
        end_cyc = cyc;
        timed_out = cyc >= 3000;
        in_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++;
        if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++;
        if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            in_valid = j[0];
            in_data = $urandom;
            @(posedge clk); #1;
            n_vec++;
            if ({in_ready, busy, out_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL idle_in_valid got rdy/busy/ov=%b want 000", {in_ready, busy, out_valid});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_basic_results(input string tag);
        n_vec++;
        if (timed_out || res_q.size() != 9) begin
            n_err++;
            $display("FAIL %s_count got %0d outputs (timeout=%0d) want 9", tag, res_q.size(), timed_out);
        end else begin
            for (int k = 0; k < 9; k++) begin
                n_vec++;
                if (res_q[k] !== basic_exp[k] || last_q[k] !== (k == 8)) begin
                    n_err++;
                    $display("FAIL %s_out%0d got %0d last=%0d want %0d last=%0d",
                             tag, k, res_q[k], last_q[k], basic_exp[k], k == 8);
                end
            end
        end
    endtask

    task automatic test_basic();
        fill_basic(1);
        run_job(0, 0);
        check_basic_results("basic");
    endtask

    task automatic test_cycle_count();
        fill_basic(1);
        run_job(0, 0);
        n_vec++;
        if (in_cyc !== 58) begin n_err++; $display("FAIL in_ready_cycles got %0d want 58", in_cyc); end
        n_vec++;
        if (first_ov - last_ld_cyc !== 10) begin
            n_err++;
            $display("FAIL first_out_latency got %0d want 10", first_ov - last_ld_cyc);
        end
        n_vec++;
        if (busy_cyc !== 148) begin n_err++; $display("FAIL busy_cycles got %0d want 148", busy_cyc); end
        n_vec++;
        if (end_cyc - last_out_cyc !== 1) begin
            n_err++;
            $display("FAIL busy_fall got %0d want 1", end_cyc - last_out_cyc);
        end
    endtask

    task automatic test_backpressure();
        fill_basic(1);
        run_job(2, 0);
        n_vec++;
        if (stall_q.size() !== 5) begin
            n_err++;
            $display("FAIL stall_len got %0d want 5", stall_q.size());
        end
        foreach (stall_q[j]) begin
            n_vec++;
            if (stall_q[j] !== 90) begin
                n_err++;
                $display("FAIL stall_data%0d got %0d want 90", j, stall_q[j]);
            end
        end
        n_vec++;
        if (last_out_cyc - first_ov !== 85) begin
            n_err++;
            $display("FAIL stall_span got %0d want 85", last_out_cyc - first_ov);
        end
        check_basic_results("bp");
    endtask

    task automatic test_relu();
        int exp0;
`ifdef CONV_SCHED_RELU_EN
        exp0 = 0;
`else
        exp0 = -72;
`endif
        fill_basic(-1);
        run_job(0, 0);
        n_vec++;
        if (res_q.size() != 9) begin
            n_err++;
            $display("FAIL relu_count got %0d want 9", res_q.size());
        end else begin
            n_vec++;
            if (res_q[0] !== exp0) begin
                n_err++;
                $display("FAIL relu_first got %h want %h", res_q[0], exp0);
            end
            for (int k = 1; k < 9; k++) begin
                n_vec++;
                if (res_q[k] !== model(k / 3, k % 3)) begin
                    n_err++;
                    $display("FAIL relu_out%0d got %0d want %0d", k, res_q[k], model(k / 3, k % 3));
                end
            end
        end
    endtask

    task automatic test_reset_mid_job();
        fill_basic(1);
        run_job(0, 3);
        n_vec++;
        if (!aborted || res_q.size() != 3) begin
            n_err++;
            $display("FAIL abort_point got aborted=%0d outs=%0d want 1 and 3", aborted, res_q.size());
        end
        n_vec++;
        if ({busy, out_valid, in_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_state got busy/ov/rdy=%b want 000", {busy, out_valid, in_ready});
        end
        run_job(0, 0);
        check_basic_results("after_abort");
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            for (int j = 0; j < 9; j++) f_arr[j] = $urandom;
            for (int j = 0; j < 49; j++) i_arr[j] = $urandom;
            run_job(1, 0);
            n_vec++;
            if (timed_out || res_q.size() != 9) begin
                n_err++;
                $display("FAIL rand%0d_count got %0d want 9", t, res_q.size());
                continue;
            end
            for (int k = 0; k < 9; k++) begin
                n_vec++;
                if (res_q[k] !== model(k / 3, k % 3) || last_q[k] !== (k == 8)) begin
                    n_err++;
                    $display("FAIL rand%0d_out%0d got %h last=%0d want %h last=%0d",
                             t, k, res_q[k], last_q[k], model(k / 3, k % 3), k == 8);
                end
            end
        end
    endtask

    task automatic test_degenerate();
        int w [18];
        int acc = 0;
        int idx = 0;
        int cyc = 0;
        for (int j = 0; j < 6; j++) begin
            in_valid3 = j[0];
            in_data3 = $urandom;
            @(posedge clk); #1;
            n_vec++;
            if ({in_ready3, busy3} !== 2'b00) begin
                n_err++;
                $display("FAIL deg_idle got rdy/busy=%b want 00", {in_ready3, busy3});
            end
        end
        for (int j = 0; j < 18; j++) w[j] = $urandom_range(0, 2000) - 1000;
        for (int j = 0; j < 9; j++) acc += w[j] * w[9+j];
        acc = relu(acc);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        while (!out_valid3 && cyc < 200) begin
            in_valid3 = idx < 18;
            in_data3 = (idx < 18) ? w[idx] : 0;
            if (in_valid3 && in_ready3) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid3 = 1'b0;
        n_vec++;
        if (!out_valid3 || out_data3 !== acc || out_last3 !== 1'b1) begin
            n_err++;
            $display("FAIL deg_out got v=%b %0d last=%b want v=1 %0d last=1",
                     out_valid3, out_data3, out_last3, acc);
        end
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        n_vec++;
        if ({busy3, out_valid3} !== 2'b00) begin
            n_err++;
            $display("FAIL deg_done got busy/ov=%b want 00", {busy3, out_valid3});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        start3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_data3 = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_cycle_count();
        test_backpressure();
        test_relu();
        test_reset_mid_job();
        test_random();
        test_degenerate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
